// File: rtl/note_player_seq.sv
// Note sequencer: latches a note, times it in beats, strobes load/note_done from state.
// One cycle from a request sampled in PLAY to load/note_done; no backpressure, ignored requests are dropped.
module note_player_seq #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter bit REPEAT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              pause,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  duration_in,
  input  logic              beat,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              load,
  output logic              note_done,
  output logic              timer_clear,
  output logic [DUR_W-1:0]  elapsed
);

  typedef enum logic [2:0] {IDLE, PLAY, LOAD, DONE, PAUSED} state_e;

  state_e              state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    elapsed_q, elapsed_d;
  logic                armed_q, armed_d;
  logic                valid_q, valid_d;
  logic                at_end;

  assign at_end = armed_q && (elapsed_q == dur_q);

  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    dur_d     = dur_q;
    elapsed_d = elapsed_q;
    armed_d   = armed_q;
    valid_d   = valid_q;

    unique case (state_q)
      IDLE: begin
        armed_d = 1'b0;
        if (play_enable) state_d = PLAY;
      end
      PLAY: begin
        if (!play_enable)       state_d = IDLE;
        else if (at_end)        state_d = DONE;
        else if (load_new_note) state_d = LOAD;
        else if (pause)         state_d = PAUSED;
        // The timer saturates at the programmed duration.
        if (beat && armed_q && (elapsed_q != dur_q)) elapsed_d = elapsed_q + DUR_W'(1);
      end
      LOAD:    state_d = PLAY;
      DONE:    state_d = PLAY;
      PAUSED: begin
        if (!play_enable) state_d = IDLE;
        else if (!pause)  state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase

    // Entry actions take precedence over the running timer.
    if (state_d != state_q) begin
      unique case (state_d)
        IDLE: begin
          valid_d   = 1'b0;
          elapsed_d = '0;
          armed_d   = 1'b0;
        end
        LOAD: begin
          note_d    = note_in;
          dur_d     = duration_in;
          elapsed_d = '0;
          armed_d   = 1'b1;
          valid_d   = 1'b1;
        end
        DONE: begin
          elapsed_d = '0;
          if (!REPEAT) begin
            armed_d = 1'b0;
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      note_q    <= '0;
      dur_q     <= '0;
      elapsed_q <= '0;
      armed_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
      elapsed_q <= elapsed_d;
      armed_q   <= armed_d;
      valid_q   <= valid_d;
    end
  end

  assign note_out    = note_q;
  assign note_valid  = valid_q;
  assign elapsed     = elapsed_q;
  assign load        = (state_q == LOAD);
  assign note_done   = (state_q == DONE);
  assign timer_clear = (state_q == IDLE) || (state_q == LOAD) || (state_q == DONE);

endmodule

// File: tb/tb_note_player_seq.sv
// Bench for note_player_seq: REPEAT=0 and REPEAT=1 instances share stimulus, checked against a behavioural model.
module tb_note_player_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, play_enable, pause, load_new_note, beat;
  logic [5:0] note_in, duration_in;
  logic [5:0] note_out_w [2];
  logic [5:0] elapsed_w  [2];
  logic       valid_w    [2];
  logic       load_w     [2];
  logic       done_w     [2];
  logic       tc_w       [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  note_player_seq #(.NOTE_W(6), .DUR_W(6), .REPEAT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .play_enable(play_enable), .pause(pause),
    .load_new_note(load_new_note), .note_in(note_in), .duration_in(duration_in), .beat(beat),
    .note_out(note_out_w[0]), .note_valid(valid_w[0]), .load(load_w[0]),
    .note_done(done_w[0]), .timer_clear(tc_w[0]), .elapsed(elapsed_w[0])
  );

  note_player_seq #(.NOTE_W(6), .DUR_W(6), .REPEAT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .play_enable(play_enable), .pause(pause),
    .load_new_note(load_new_note), .note_in(note_in), .duration_in(duration_in), .beat(beat),
    .note_out(note_out_w[1]), .note_valid(valid_w[1]), .load(load_w[1]),
    .note_done(done_w[1]), .timer_clear(tc_w[1]), .elapsed(elapsed_w[1])
  );

  // Behavioural model: what the player is doing, the note it holds and how many beats it has counted.
  localparam int M_IDLE = 0, M_PLAY = 1, M_LOAD = 2, M_DONE = 3, M_PAUSE = 4;
  typedef struct {
    int st;
    int note;
    int dur;
    int el;
    bit armed;
    bit valid;
  } mdl_t;
  mdl_t mdl [2];

  function automatic mdl_t next_mdl(mdl_t m, bit rep);
    mdl_t n = m;
    if (reset) begin
      n.st = M_IDLE; n.note = 0; n.dur = 0; n.el = 0; n.armed = 0; n.valid = 0;
      return n;
    end
    if (m.st == M_IDLE) begin
      n.armed = 0;
      if (play_enable) n.st = M_PLAY;
    end else if (m.st == M_LOAD || m.st == M_DONE) begin
      n.st = M_PLAY;
    end else if (m.st == M_PAUSE) begin
      if (!play_enable) n.st = M_IDLE;
      else if (!pause)  n.st = M_PLAY;
    end else begin
      if (beat && m.armed && m.el < m.dur) n.el = m.el + 1;
      if (!play_enable) begin
        n.st = M_IDLE;
      end else if (m.armed && m.el == m.dur) begin
        n.st = M_DONE; n.el = 0;
        if (!rep) begin n.armed = 0; n.valid = 0; end
      end else if (load_new_note) begin
        n.st = M_LOAD; n.note = note_in; n.dur = duration_in; n.el = 0; n.armed = 1; n.valid = 1;
      end else if (pause) begin
        n.st = M_PAUSE;
      end
    end
    if (n.st == M_IDLE && m.st != M_IDLE) begin
      n.valid = 0; n.el = 0; n.armed = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mdl[0] <= next_mdl(mdl[0], 1'b0);
    mdl[1] <= next_mdl(mdl[1], 1'b1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("note_out[%0d]", i), int'(note_out_w[i]), mdl[i].note);
        chk($sformatf("elapsed[%0d]", i), int'(elapsed_w[i]), mdl[i].el);
        chk($sformatf("note_valid[%0d]", i), int'(valid_w[i]), int'(mdl[i].valid));
        chk($sformatf("load[%0d]", i), int'(load_w[i]), int'(mdl[i].st == M_LOAD));
        chk($sformatf("note_done[%0d]", i), int'(done_w[i]), int'(mdl[i].st == M_DONE));
        chk($sformatf("timer_clear[%0d]", i), int'(tc_w[i]),
            int'(mdl[i].st == M_IDLE || mdl[i].st == M_LOAD || mdl[i].st == M_DONE));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  int cnt0, cnt1;

  initial begin
    reset = 1; play_enable = 0; pause = 0; load_new_note = 0; beat = 0; note_in = 0; duration_in = 0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_tc", tc_w[0], 1);
    chk("rst_note", note_out_w[0], 0);
    chk("rst_el", elapsed_w[0], 0);
    chk("rst_load", load_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_valid", valid_w[0], 0);

    // Basic note: 5 for 3 beats.
    reset = 0; play_enable = 1; step();
    chk("play_tc", tc_w[0], 0);
    load_new_note = 1; note_in = 6'd5; duration_in = 6'd3; step();
    chk("ld_load", load_w[0], 1);
    chk("ld_note", note_out_w[0], 5);
    chk("ld_valid", valid_w[0], 1);
    load_new_note = 0; beat = 1; step();
    chk("ld_exit_load", load_w[0], 0);
    chk("el0", elapsed_w[0], 0);
    step(); chk("el1", elapsed_w[0], 1);
    step(); chk("el2", elapsed_w[0], 2);
    step(); chk("el3", elapsed_w[0], 3);
    beat = 0; step();
    chk("done_pulse", done_w[0], 1);
    chk("done_valid0", valid_w[0], 0);
    chk("done_valid_rep", valid_w[1], 1);
    chk("done_el", elapsed_w[0], 0);
    step();
    chk("done_one_cycle", done_w[0], 0);

    // Repeat: duration 2, 6 effective beats.
    load_new_note = 1; note_in = 6'd9; duration_in = 6'd2; step();
    load_new_note = 0; beat = 1; cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      cnt0 += int'(done_w[0]); cnt1 += int'(done_w[1]);
      chk("rep_valid", valid_w[1], 1);
    end
    beat = 0; step();
    cnt0 += int'(done_w[0]); cnt1 += int'(done_w[1]);
    chk("rep_done_count", cnt1, 3);
    chk("norep_done_count", cnt0, 1);

    // Pause at elapsed=1 for 10 beats; load request while paused is dropped.
    load_new_note = 1; note_in = 6'd7; duration_in = 6'd5; step();
    load_new_note = 0; step();
    beat = 1; step();
    chk("pz_el1", elapsed_w[0], 1);
    beat = 0; pause = 1; step();
    beat = 1; load_new_note = 1; note_in = 6'd63;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pz_hold_el", elapsed_w[0], 1);
      chk("pz_hold_note", note_out_w[0], 7);
    end
    load_new_note = 0; beat = 0; pause = 0; step();
    chk("pz_release_load", load_w[0], 0);
    beat = 1; repeat (4) step();
    chk("pz_el5", elapsed_w[0], 5);
    beat = 0; step();
    chk("pz_done", done_w[0], 1);
    step();

    // Zero duration: done right after the first PLAY cycle, no beat.
    load_new_note = 1; note_in = 6'd3; duration_in = 6'd0; step();
    load_new_note = 0; step();
    chk("z_play", done_w[0], 0);
    step();
    chk("z_done", done_w[0], 1);
    step();

    // Load request coincides with end of note: DONE wins.
    load_new_note = 1; note_in = 6'd4; duration_in = 6'd2; step();
    load_new_note = 0; beat = 1; step(); step(); step();
    beat = 0; load_new_note = 1; note_in = 6'd8; duration_in = 6'd9; step();
    chk("col_load", load_w[0], 0);
    chk("col_done", done_w[0], 1);
    chk("col_note", note_out_w[0], 4);
    load_new_note = 0; step();

    // play_enable dropped mid-note.
    load_new_note = 1; note_in = 6'd10; duration_in = 6'd6; step();
    load_new_note = 0; beat = 1; step(); step();
    play_enable = 0; beat = 0; step();
    chk("abort_valid", valid_w[0], 0);
    chk("abort_tc", tc_w[0], 1);
    chk("abort_el", elapsed_w[0], 0);
    chk("abort_note", note_out_w[0], 10);

    // Reset while paused at elapsed=4.
    play_enable = 1; step();
    load_new_note = 1; note_in = 6'd12; duration_in = 6'd20; step();
    load_new_note = 0; beat = 1; step();
    repeat (4) step();
    chk("rp_el4", elapsed_w[0], 4);
    beat = 0; pause = 1; step();
    chk("rp_paused_el", elapsed_w[0], 4);
    chk("rp_paused_tc", tc_w[0], 0);
    reset = 1; step();
    chk("rp_el", elapsed_w[0], 0);
    chk("rp_note", note_out_w[0], 0);
    chk("rp_load", load_w[0], 0);
    chk("rp_done", done_w[0], 0);
    chk("rp_valid", valid_w[0], 0);
    chk("rp_tc", tc_w[0], 1);
    reset = 0; pause = 0; play_enable = 0; step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_player_seq.md
NOTE_PLAYER_SEQ -- requirements
Module: note_player_seq

Interface
REQ-001 SHALL have parameter NOTE_W, default 6, width of note code.
REQ-002 SHALL have parameter DUR_W, default 6, width of note duration in beats.
REQ-003 SHALL have parameter REPEAT, default 0; 1 = replay the current note after it finishes.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port play_enable  input  1  high = playing allowed; low = abort to IDLE.
REQ-007 SHALL have port pause  input  1  high = freeze the timer, hold the note.
REQ-008 SHALL have port load_new_note  input  1  request to load note_in/duration_in.
REQ-009 SHALL have port note_in  input  NOTE_W  note code to load.
REQ-010 SHALL have port duration_in  input  DUR_W  note length in beats.
REQ-011 SHALL have port beat  input  1  one-cycle beat tick.
REQ-012 SHALL have port note_out  output  NOTE_W  currently held note code.
REQ-013 SHALL have port note_valid  output  1  note_out is sounding.
REQ-014 SHALL have port load  output  1  one-cycle load strobe.
REQ-015 SHALL have port note_done  output  1  one-cycle end-of-note strobe.
REQ-016 SHALL have port timer_clear  output  1  timer being cleared this cycle.
REQ-017 SHALL have port elapsed  output  DUR_W  beats counted for the current note.

Function
REQ-018 SHALL implement a Moore FSM with states IDLE, PLAY, LOAD, DONE and PAUSED; load, note_done and timer_clear are decoded from the state only.
REQ-019 IDLE: timer_clear=1 and armed cleared; play_enable=1 -> PLAY, else stay.
REQ-020 PLAY transition priority: !play_enable -> IDLE; then armed && elapsed==dur_reg -> DONE; then load_new_note -> LOAD; then pause -> PAUSED; else PLAY.
REQ-021 On the edge that enters LOAD, SHALL capture note_in->note_out and duration_in->dur_reg, clear elapsed to 0, and set armed and note_valid.
REQ-022 LOAD: load=1 and timer_clear=1 for exactly one cycle, then -> PLAY unconditionally.
REQ-023 DONE: note_done=1 and timer_clear=1 for exactly one cycle, then -> PLAY; on entry elapsed is cleared to 0.
REQ-024 On entry to DONE with REPEAT=0, SHALL clear armed and note_valid; with REPEAT=1, SHALL keep both set so the note replays from elapsed=0.
REQ-025 Timer: in PLAY with beat=1, armed=1 and elapsed!=dur_reg, elapsed SHALL increment by 1; it never wraps.
REQ-026 duration_in=0 SHALL give DONE on the first PLAY cycle after LOAD, with no beat needed.
REQ-027 PAUSED: elapsed, note_out and note_valid SHALL be frozen and beat ignored; !play_enable -> IDLE; else !pause -> PLAY; else stay.
REQ-028 A load_new_note in LOAD, DONE, PAUSED or IDLE SHALL be ignored and not queued.
REQ-029 Entry to IDLE SHALL clear note_valid and elapsed; note_out keeps its last value.
REQ-030 Latency SHALL be one cycle from a request sampled in PLAY to load or note_done high.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE from any state and override every other input.
REQ-032 After reset, note_out=0, note_valid=0, elapsed=0, dur_reg=0, armed=0, load=0 and note_done=0.
REQ-033 After reset, timer_clear=1, because IDLE is entered.

Verification
REQ-034 Reset then play_enable=1; load_new_note with note_in=5, duration_in=3; 3 beats -> load pulses once with note_out=5 and note_valid=1; elapsed goes 1,2,3; note_done pulses one cycle after elapsed=3; then note_valid=0.
REQ-035 REPEAT=1, duration 2, 6 beats -> note_done pulses 3 times; note_valid stays 1 throughout.
REQ-036 Pause asserted at elapsed=1 for 10 cycles with beats -> elapsed holds 1; after release it resumes counting to done.
REQ-037 Load with duration_in=0 -> note_done one cycle after leaving LOAD, with no beat applied.
REQ-038 load_new_note and done condition in the same PLAY cycle -> DONE wins, no load pulse; play_enable dropped mid-note -> IDLE, note_valid=0, timer_clear=1.
REQ-039 reset asserted during PAUSED with elapsed=4 -> next cycle IDLE, elapsed=0, note_out=0, all strobes low.
